// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multicycle RV32M unit beside the ALU.
// Multiplies take one registered step. Divides use restoring division, one
// quotient bit per clock, followed by a sign-fix step. oValid and oResult are
// registered as the sequencer leaves DONE.
module muldiv_sequencer #(
  parameter int EARLY_OUT = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iValid,
  input  logic [4:0]  iControl,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iFlush,
  output logic        oReady,
  output logic        oBusy,
  output logic        oValid,
  output logic [31:0] oResult
);

  // Operation codes shared with the ALU control field
  localparam logic [4:0] OPMUL    = 5'd11;
  localparam logic [4:0] OPMULH   = 5'd12;
  localparam logic [4:0] OPMULHSU = 5'd13;
  localparam logic [4:0] OPMULHU  = 5'd14;
  localparam logic [4:0] OPDIV    = 5'd15;
  localparam logic [4:0] OPDIVU   = 5'd16;
  localparam logic [4:0] OPREM    = 5'd17;
  localparam logic [4:0] OPREMU   = 5'd18;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_op;
  logic [32:0] r_a, r_b;        // sign-extended multiplicands / divisor magnitude
  logic [31:0] r_rem, r_quo;    // remainder:quotient pair, also {prod_hi, prod_lo}
  logic [4:0]  r_cnt;
  logic        r_neg_q, r_neg_r;
  logic        r_valid;
  logic [31:0] r_result;

  logic        w_accept, w_is_mul, w_is_div, w_sgn_a, w_sgn_b, w_sgn_div;
  logic        w_b_zero, w_ovf, w_early;
  logic [31:0] w_abs_a, w_abs_b;
  logic [63:0] w_a64, w_b64, w_prod;
  logic [32:0] w_shift, w_diff;

  // No accept while the result pulse is still on the output
  assign w_accept = (r_state == S_IDLE) && !r_valid && iValid;

  assign w_is_mul  = (iControl == OPMUL) || (iControl == OPMULH) ||
                     (iControl == OPMULHSU) || (iControl == OPMULHU);
  assign w_is_div  = (iControl == OPDIV) || (iControl == OPDIVU) ||
                     (iControl == OPREM) || (iControl == OPREMU);
  assign w_sgn_a   = (iControl == OPMUL) || (iControl == OPMULH) || (iControl == OPMULHSU);
  assign w_sgn_b   = (iControl == OPMUL) || (iControl == OPMULH);
  assign w_sgn_div = (iControl == OPDIV) || (iControl == OPREM);

  assign w_abs_a  = (w_sgn_div && iA[31]) ? (~iA + 32'd1) : iA;
  assign w_abs_b  = (w_sgn_div && iB[31]) ? (~iB + 32'd1) : iB;
  assign w_b_zero = (iB == 32'd0);
  assign w_ovf    = w_sgn_div && (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);
  assign w_early  = (EARLY_OUT != 0) && w_is_div && (w_b_zero || w_ovf);

  // Low 64 bits of a 64x64 product of sign-extended operands give the
  // correct signed/unsigned 32x32 product for every MUL variant
  assign w_a64  = {{31{r_a[32]}}, r_a};
  assign w_b64  = {{31{r_b[32]}}, r_b};
  assign w_prod = w_a64 * w_b64;

  // Restoring step: bit 32 of the trial difference is the borrow
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_b[31:0]};

  // State register
  always_ff @(posedge iCLK) begin
    if (!iRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a flush aborts only the working states
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_early)       w_next = S_DONE;
        else if (w_is_mul) w_next = S_MUL;
        else if (w_is_div) w_next = S_DIV;
        else               w_next = S_DONE;
      end
      S_MUL:  w_next = S_DONE;
      S_DIV:  if (r_cnt == 5'd0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (iFlush && ((r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX)))
      w_next = S_IDLE;
  end

  // Datapath: operand capture, multiply, divide iterations, sign fix, result
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= iControl;
          r_a     <= {w_sgn_a & iA[31], iA};
          r_b     <= w_is_div ? {1'b0, w_abs_b} : {w_sgn_b & iB[31], iB};
          r_quo   <= w_abs_a;
          r_rem   <= '0;
          r_cnt   <= 5'd31;
          // Divide by zero keeps the all-ones quotient unsigned
          r_neg_q <= w_sgn_div && (iA[31] ^ iB[31]) && !w_b_zero;
          r_neg_r <= w_sgn_div && iA[31];
          if (w_early) begin
            r_quo <= w_b_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            r_rem <= w_b_zero ? iA : 32'd0;
          end
        end
        S_MUL: {r_rem, r_quo} <= w_prod;
        S_DIV: begin
          r_rem <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
          r_quo <= {r_quo[30:0], ~w_diff[32]};
          r_cnt <= r_cnt - 5'd1;
        end
        S_FIX: begin
          if (r_neg_q) r_quo <= ~r_quo + 32'd1;
          if (r_neg_r) r_rem <= ~r_rem + 32'd1;
        end
        S_DONE: begin
          r_valid <= 1'b1;
          case (r_op)
            OPMUL:                              r_result <= r_quo;
            OPMULH, OPMULHSU, OPMULHU:          r_result <= r_rem;
            OPDIV, OPDIVU:                      r_result <= r_quo;
            OPREM, OPREMU:                      r_result <= r_rem;
            default:                            r_result <= 32'd0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign oReady  = (r_state == S_IDLE) && !r_valid;
  assign oBusy   = (r_state != S_IDLE);
  assign oValid  = r_valid;
  assign oResult = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: one instance with early-out enabled,
// one always iterating, both driven by the same stimulus.
module tb_muldiv_sequencer;

  localparam logic [4:0] OPADD    = 5'd3;
  localparam logic [4:0] OPMUL    = 5'd11;
  localparam logic [4:0] OPMULH   = 5'd12;
  localparam logic [4:0] OPMULHSU = 5'd13;
  localparam logic [4:0] OPMULHU  = 5'd14;
  localparam logic [4:0] OPDIV    = 5'd15;
  localparam logic [4:0] OPDIVU   = 5'd16;
  localparam logic [4:0] OPREM    = 5'd17;
  localparam logic [4:0] OPREMU   = 5'd18;

  logic        clk = 1'b0;
  logic        iRST = 1'b0;
  logic        iValid = 1'b0;
  logic [4:0]  iControl = '0;
  logic [31:0] iA = '0, iB = '0;
  logic        iFlush = 1'b0;
  logic        rdy0, busy0, vld0, rdy1, busy1, vld1;
  logic [31:0] res0, res1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.EARLY_OUT(1)) u_dut_eo (
    .iCLK(clk), .iRST(iRST), .iValid(iValid), .iControl(iControl),
    .iA(iA), .iB(iB), .iFlush(iFlush),
    .oReady(rdy0), .oBusy(busy0), .oValid(vld0), .oResult(res0));

  muldiv_sequencer #(.EARLY_OUT(0)) u_dut_it (
    .iCLK(clk), .iRST(iRST), .iValid(iValid), .iControl(iControl),
    .iA(iA), .iB(iB), .iFlush(iFlush),
    .oReady(rdy1), .oBusy(busy1), .oValid(vld1), .oResult(res1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op to both instances and measure accept-to-oValid latency.
  // poke=1 raises iValid with another op while the unit is busy.
  task automatic run_op(input string tag, input logic [4:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat0, input int lat1, input bit poke);
    int l0, l1;
    logic [31:0] r0, r1;
    logic busy_ok;
    l0 = -1; l1 = -1; r0 = '0; r1 = '0; busy_ok = 1'b1;
    iValid = 1'b1; iControl = ctl; iA = a; iB = b;
    tick();                                  // accept edge T
    iValid = 1'b0;
    iA = $urandom(); iB = $urandom(); iControl = 5'($urandom());
    for (int k = 1; k <= 40 && (l0 < 0 || l1 < 0); k++) begin
      if (l0 < 0 && busy0 !== 1'b1) busy_ok = 1'b0;
      if (poke && k == 5)  begin iValid = 1'b1; iControl = OPMUL; end
      if (poke && k == 10) iValid = 1'b0;
      tick();
      if (l0 < 0 && vld0 === 1'b1) begin l0 = k; r0 = res0; end
      if (l1 < 0 && vld1 === 1'b1) begin l1 = k; r1 = res1; end
    end
    chk({tag, "/lat_eo"}, 32'(l0), 32'(lat0));
    chk({tag, "/res_eo"}, r0, exp);
    chk({tag, "/lat_it"}, 32'(l1), 32'(lat1));
    chk({tag, "/res_it"}, r1, exp);
    chk({tag, "/busy"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "/busy_at_valid"}, {31'd0, busy1}, 32'd0);
    tick();
    chk({tag, "/ready_after"}, {30'd0, rdy0, rdy1}, 32'd3);
    chk({tag, "/pulse_once"}, {30'd0, vld0, vld1}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;

    // Reset
    repeat (3) tick();
    chk("rst/ready", {31'd0, rdy0}, 32'd1);
    chk("rst/busy",  {31'd0, busy0}, 32'd0);
    chk("rst/valid", {31'd0, vld0}, 32'd0);
    chk("rst/result", res0, 32'd0);
    iRST = 1'b1;
    tick();

    // Multiplies
    run_op("mul",    OPMUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 2, 1'b0);
    run_op("mulh",   OPMULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2, 2, 1'b0);
    run_op("mulhsu", OPMULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 2, 1'b0);
    run_op("mulhu",  OPMULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 2, 1'b0);

    // Divides, with an ignored request raised while busy
    run_op("div",    OPDIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 34, 1'b1);
    run_op("rem",    OPREM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 34, 1'b0);
    run_op("div_nb", OPDIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 34, 1'b0);
    run_op("rem_nb", OPREM,  32'd7, 32'hFFFF_FFFE, 32'd1,         34, 34, 1'b0);
    run_op("divu",   OPDIVU, 32'd100, 32'd7, 32'd14, 34, 34, 1'b0);
    run_op("remu",   OPREMU, 32'd100, 32'd7, 32'd2,  34, 34, 1'b0);

    // Special cases: early-out instance at T+1, iterating one at T+34
    run_op("divu_z", OPDIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, 34, 1'b0);
    run_op("remu_z", OPREMU, 32'd5,         32'd0, 32'd5,         1, 34, 1'b0);
    run_op("div_z",  OPDIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, 34, 1'b0);
    run_op("rem_z",  OPREM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 34, 1'b0);
    run_op("div_ov", OPDIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 34, 1'b0);
    run_op("rem_ov", OPREM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 34, 1'b0);

    // Non-M codes return 0
    run_op("unk31",  5'd31,  32'd9, 32'd9, 32'd0, 1, 1, 1'b0);
    run_op("mul_nz", OPMUL,  32'd6, 32'd7, 32'd42, 2, 2, 1'b0);
    run_op("unkadd", OPADD,  32'd9, 32'd9, 32'd0, 1, 1, 1'b0);
    run_op("mul_b",  OPMUL,  32'd6, 32'd7, 32'd42, 2, 2, 1'b0);

    // Flush during divide: no pulse, result held, unit ready again
    held = res0;
    iValid = 1'b1; iControl = OPDIV; iA = 32'd100; iB = 32'd3;
    tick();
    iValid = 1'b0;
    repeat (9) tick();
    iFlush = 1'b1;
    tick();                                  // edge T+10
    iFlush = 1'b0;
    chk("flush/valid", {30'd0, vld0, vld1}, 32'd0);
    chk("flush/busy",  {30'd0, busy0, busy1}, 32'd0);
    tick();                                  // T+11
    chk("flush/ready", {30'd0, rdy0, rdy1}, 32'd3);
    chk("flush/held",  res0, held);
    run_op("mul_aft", OPMUL, 32'd5, 32'd9, 32'd45, 2, 2, 1'b0);

    // Flush in IDLE does not block accept; flush in DONE keeps the pulse
    iFlush = 1'b1; iValid = 1'b1; iControl = OPMULHU; iA = 32'hFFFF_FFFF; iB = 32'd2;
    tick();                                  // T
    iFlush = 1'b0; iValid = 1'b0;
    chk("fidle/busy", {31'd0, busy0}, 32'd1);
    tick();                                  // T+1, now in DONE
    iFlush = 1'b1;
    tick();                                  // T+2
    iFlush = 1'b0;
    chk("fdone/valid", {30'd0, vld0, vld1}, 32'd3);
    chk("fdone/res",   res0, 32'd1);

    // No accept while oValid is high; accepted on the following edge
    iValid = 1'b1; iControl = OPMUL; iA = 32'd2; iB = 32'd2;
    tick();                                  // edge while oValid=1
    chk("b2b/not_taken", {31'd0, busy0}, 32'd0);
    chk("b2b/ready",     {31'd0, rdy0}, 32'd1);
    tick();
    iValid = 1'b0;
    chk("b2b/taken", {31'd0, busy0}, 32'd1);
    repeat (2) tick();
    chk("b2b/valid", {31'd0, vld0}, 32'd1);
    chk("b2b/res",   res0, 32'd4);
    tick();

    // Reset in the middle of a divide
    iValid = 1'b1; iControl = OPDIVU; iA = 32'd1000; iB = 32'd3;
    tick();
    iValid = 1'b0;
    repeat (5) tick();
    iRST = 1'b0;
    tick();
    chk("mrst/ready",  {30'd0, rdy0, rdy1}, 32'd3);
    chk("mrst/busy",   {30'd0, busy0, busy1}, 32'd0);
    chk("mrst/valid",  {30'd0, vld0, vld1}, 32'd0);
    chk("mrst/result", res0 | res1, 32'd0);
    iRST = 1'b1;
    tick();
    run_op("mul_end", OPMULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
